// File: rtl/hps_instr_bridge_if.sv
// HPS instruction bridge bus: push strobe and word pair in, FWFT read port and status out.
interface hps_instr_bridge_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wrreg;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              screen;
    logic              reset_pulsecounter;
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wrfull;
    logic              almost_full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic [15:0]       drop_count;
    logic [15:0]       frame_count;

    modport slave (
        input  wrreg, data_a, data_b, screen, reset_pulsecounter, rd_en,
        output rd_valid, rd_data_a, rd_data_b, wrfull, almost_full, empty,
               level, drop_count, frame_count
    );

    modport master (
        output wrreg, data_a, data_b, screen, reset_pulsecounter, rd_en,
        input  rd_valid, rd_data_a, rd_data_b, wrfull, almost_full, empty,
               level, drop_count, frame_count
    );
endinterface

// File: rtl/hps_instr_bridge.sv
// Edge-triggered HPS instruction FIFO with first-word-fall-through read, optional
// vertical-blank gating of the read side, drop counter and frame counter.
module hps_instr_bridge #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int GATE_SCREEN = 0
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    hps_instr_bridge_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 2 * DATA_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_LEVEL);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [15:0]      drop_r;
    logic [15:0]      frame_r;
    logic             wrreg_q_r;
    logic             screen_q_r;

    logic             push_req_s;
    logic             empty_s;
    logic             gate_open_s;
    logic             rd_valid_s;
    logic             pop_s;
    logic             wr_accept_s;
    logic             drop_s;
    logic             screen_rise_s;

    // Push/pop qualification; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        push_req_s    = bus.wrreg & ~wrreg_q_r;
        screen_rise_s = bus.screen & ~screen_q_r;
        empty_s       = (level_r == '0);
        if (GATE_SCREEN != 0) begin
            gate_open_s = bus.screen;
        end else begin
            gate_open_s = 1'b1;
        end
        rd_valid_s  = ~empty_s & gate_open_s;
        pop_s       = bus.rd_en & rd_valid_s;
        wr_accept_s = push_req_s & ((level_r != FULL_LVL) | pop_s);
        drop_s      = push_req_s & ~wr_accept_s;
    end

    // Storage array; contents are don't-care while empty, so it carries no reset.
    always_ff @(posedge clk_clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= {bus.data_a, bus.data_b};
        end
    end

    // Edge detectors, pointers and occupancy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wrreg_q_r  <= 1'b1;
            screen_q_r <= 1'b1;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
        end else begin
            wrreg_q_r  <= bus.wrreg;
            screen_q_r <= bus.screen;
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_accept_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Drop and frame counters; a counter clear wins over a coincident screen edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            drop_r  <= 16'd0;
            frame_r <= 16'd0;
        end else begin
            if (drop_s) begin
                drop_r <= sat_inc16(drop_r);
            end
            if (bus.reset_pulsecounter) begin
                frame_r <= 16'd0;
            end else if (screen_rise_s) begin
                frame_r <= frame_r + 16'd1;
            end
        end
    end

    // Output drive; head data is forced to zero whenever the FIFO is empty.
    always_comb begin
        bus.rd_valid    = rd_valid_s;
        bus.empty       = empty_s;
        bus.wrfull      = (level_r == FULL_LVL);
        bus.almost_full = (level_r >= AF_LVL);
        bus.level       = level_r;
        bus.drop_count  = drop_r;
        bus.frame_count = frame_r;
        if (empty_s) begin
            bus.rd_data_a = '0;
            bus.rd_data_b = '0;
        end else begin
            bus.rd_data_a = mem_r[rd_ptr_r][ENT_W-1:DATA_W];
            bus.rd_data_b = mem_r[rd_ptr_r][DATA_W-1:0];
        end
    end
endmodule

// File: tb/tb_hps_instr_bridge.sv
// Directed bench for hps_instr_bridge: an ungated DEPTH=4 instance and a screen-gated one.
module tb_hps_instr_bridge;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hps_instr_bridge_if #(.DATA_W(32), .DEPTH(4)) bm ();
    hps_instr_bridge_if #(.DATA_W(32), .DEPTH(4)) bg ();

    hps_instr_bridge #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(2), .GATE_SCREEN(0)) u_dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bm)
    );

    hps_instr_bridge #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(2), .GATE_SCREEN(1)) u_dut_g (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit sel, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            bg.data_a = a; bg.data_b = b; bg.wrreg = 1'b1;
        end else begin
            bm.data_a = a; bm.data_b = b; bm.wrreg = 1'b1;
        end
        tick();
        bm.wrreg = 1'b0;
        bg.wrreg = 1'b0;
        tick();
    endtask

    task automatic pop_main();
        bm.rd_en = 1'b1;
        tick();
        bm.rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_a [4];
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bm.wrreg = 1'b0; bm.data_a = '0; bm.data_b = '0; bm.screen = 1'b0;
        bm.reset_pulsecounter = 1'b0; bm.rd_en = 1'b0;
        bg.wrreg = 1'b0; bg.data_a = '0; bg.data_b = '0; bg.screen = 1'b0;
        bg.reset_pulsecounter = 1'b0; bg.rd_en = 1'b0;
        tick();
        tick();

        check_eq("rst_empty",    32'(bm.empty), 32'd1);
        check_eq("rst_wrfull",   32'(bm.wrfull), 32'd0);
        check_eq("rst_af",       32'(bm.almost_full), 32'd0);
        check_eq("rst_rd_valid", 32'(bm.rd_valid), 32'd0);
        check_eq("rst_rd_a",     bm.rd_data_a, 32'd0);
        check_eq("rst_rd_b",     bm.rd_data_b, 32'd0);
        check_eq("rst_level",    32'(bm.level), 32'd0);

        rst_n = 1'b1;
        tick();

        // Single push shows up at the head one cycle after the strobe edge.
        push(1'b0, 32'h11, 32'h22);
        check_eq("one_valid", 32'(bm.rd_valid), 32'd1);
        check_eq("one_rd_a",  bm.rd_data_a, 32'h11);
        check_eq("one_rd_b",  bm.rd_data_b, 32'h22);
        check_eq("one_level", 32'(bm.level), 32'd1);
        pop_main();
        check_eq("one_empty", 32'(bm.empty), 32'd1);
        check_eq("one_rd_a0", bm.rd_data_a, 32'd0);

        // Overfill: six edges into four slots.
        for (int i = 1; i <= 6; i++) begin
            push(1'b0, 32'(i), 32'(i) + 32'h100);
        end
        check_eq("full_level",  32'(bm.level), 32'd4);
        check_eq("full_wrfull", 32'(bm.wrfull), 32'd1);
        check_eq("full_af",     32'(bm.almost_full), 32'd1);
        check_eq("full_drops",  32'(bm.drop_count), 32'd2);
        check_eq("full_head_b", bm.rd_data_b, 32'h101);

        // Push and pop together while full.
        bm.data_a = 32'h7; bm.data_b = 32'h107;
        bm.wrreg = 1'b1; bm.rd_en = 1'b1;
        tick();
        bm.wrreg = 1'b0; bm.rd_en = 1'b0;
        tick();
        check_eq("pp_level", 32'(bm.level), 32'd4);
        check_eq("pp_drops", 32'(bm.drop_count), 32'd2);

        exp_a[0] = 32'h2; exp_a[1] = 32'h3; exp_a[2] = 32'h4; exp_a[3] = 32'h7;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain_a%0d", i), bm.rd_data_a, exp_a[i]);
            check_eq($sformatf("drain_b%0d", i), bm.rd_data_b, exp_a[i] + 32'h100);
            pop_main();
        end
        check_eq("drain_empty", 32'(bm.empty), 32'd1);
        pop_main();
        check_eq("underflow_level", 32'(bm.level), 32'd0);

        // Gated instance: entries held while screen is low.
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 32'h31 + 32'(i), 32'h41 + 32'(i));
        end
        check_eq("gate_level", 32'(bg.level), 32'd3);
        check_eq("gate_valid", 32'(bg.rd_valid), 32'd0);
        bg.rd_en = 1'b1;
        tick();
        check_eq("gate_ignored", 32'(bg.level), 32'd3);
        bg.screen = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("gate_valid%0d", i), 32'(bg.rd_valid), 32'd1);
            check_eq($sformatf("gate_a%0d", i), bg.rd_data_a, 32'h31 + 32'(i));
            tick();
        end
        bg.rd_en = 1'b0;
        check_eq("gate_drained", 32'(bg.level), 32'd0);

        // Frame counter: three pulses, then clear coincident with a fourth edge.
        for (int i = 0; i < 3; i++) begin
            bm.screen = 1'b1; tick();
            bm.screen = 1'b0; tick();
        end
        check_eq("frames3", 32'(bm.frame_count), 32'd3);
        bm.screen = 1'b1; bm.reset_pulsecounter = 1'b1;
        tick();
        bm.reset_pulsecounter = 1'b0;
        check_eq("frames_clr", 32'(bm.frame_count), 32'd0);
        bm.screen = 1'b0; tick();

        // Mid-operation reset with wrreg and screen held high across release.
        push(1'b0, 32'h99, 32'h98);
        check_eq("pre_rst_level", 32'(bm.level), 32'd1);
        bm.wrreg = 1'b1; bm.screen = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_level", 32'(bm.level), 32'd0);
        check_eq("async_drops", 32'(bm.drop_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("held_level",  32'(bm.level), 32'd0);
        check_eq("held_frames", 32'(bm.frame_count), 32'd0);
        bm.wrreg = 1'b0; bm.screen = 1'b0;
        tick();
        push(1'b0, 32'h55, 32'h66);
        check_eq("post_rst_level", 32'(bm.level), 32'd1);
        check_eq("post_rst_a",     bm.rd_data_a, 32'h55);
        check_eq("post_rst_b",     bm.rd_data_b, 32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hps_instr_bridge.md
HPS_INSTR_BRIDGE -- requirements
Module: hps_instr_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each instruction word (data_a, data_b).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold; range 1..DEPTH.
REQ-004 SHALL have parameter GATE_SCREEN, default 0; 1 = release entries only while screen=1.
REQ-005 SHALL have port clk_clk, input, 1, single clock for all logic.
REQ-006 SHALL have port reset_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wrreg, input, 1, HPS write strobe; a push is requested on each rising edge.
REQ-008 SHALL have ports data_a and data_b, input, DATA_W each, instruction word pair.
REQ-009 SHALL have port screen, input, 1, high during the vertical-blank window.
REQ-010 SHALL have port reset_pulsecounter, input, 1, synchronous clear of frame_count.
REQ-011 SHALL have port rd_en, input, 1, consumer pop request.
REQ-012 SHALL have ports rd_valid (output, 1), rd_data_a and rd_data_b (output, DATA_W each), FIFO head.
REQ-013 SHALL have ports wrfull, almost_full and empty, output, 1 each, FIFO status.
REQ-014 SHALL have port level, output, clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have ports drop_count and frame_count, output, 16 each.

Function
REQ-016 SHALL register wrreg into wrreg_q each cycle and detect an edge when wrreg=1 and wrreg_q=0.
REQ-017 On an edge, SHALL write {data_a, data_b} sampled at that clock edge to the tail.
REQ-018 SHALL accept a write when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
REQ-019 SHALL discard a rejected write and increment drop_count, saturating at 0xFFFF.
REQ-020 SHALL be first-word-fall-through: rd_valid = !empty AND (GATE_SCREEN=0 OR screen=1).
REQ-021 SHALL drive rd_data_a and rd_data_b from the head entry when !empty, and drive 0 when empty.
REQ-022 SHALL pop when rd_en=1 and rd_valid=1; rd_en with rd_valid=0 SHALL have no effect.
REQ-023 SHALL give a write-to-rd_valid latency of 1 cycle into an empty FIFO when not gated.
REQ-024 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-025 SHALL wrap both pointers modulo DEPTH.
REQ-026 SHALL drive wrfull = (level==DEPTH), almost_full = (level>=AF_LEVEL) and empty = (level==0), all from registered level.
REQ-027 SHALL increment frame_count on each rising edge of screen, wrapping 0xFFFF->0.
REQ-028 SHALL give reset_pulsecounter=1 priority over a simultaneous screen edge, forcing frame_count to 0.

Reset
REQ-029 On reset_reset_n=0, SHALL asynchronously set pointers, level, drop_count and frame_count to 0.
REQ-030 During reset, SHALL drive empty=1, wrfull=0, almost_full=0, rd_valid=0, rd_data_a=0 and rd_data_b=0.
REQ-031 SHALL reset wrreg_q and screen_q to 1, so a wrreg or screen held high through reset release causes no push or count.
REQ-032 SHALL discard the FIFO contents when reset is asserted mid-operation; the first edge after release SHALL land at entry 0.

Verification
REQ-033 With DEPTH=4 and GATE_SCREEN=0, pulse wrreg with a=0x11, b=0x22 -> rd_valid=1 next cycle, rd_data_a=0x11, rd_data_b=0x22, level=1.
REQ-034 With DEPTH=4, perform 6 edges with no reads -> level=4, wrfull=1, drop_count=2, and reads return entries 1..4 in order.
REQ-035 With the FIFO full, apply an edge together with rd_en=1 -> level stays 4, drop_count is unchanged, and the new word is read last.
REQ-036 With GATE_SCREEN=1, hold 3 entries with screen=0 -> rd_valid=0 and rd_en is ignored; raise screen -> 3 consecutive pops succeed.
REQ-037 Apply 3 screen pulses, then reset_pulsecounter coincident with a 4th edge -> frame_count=0; wrreg held high across reset release -> level=0.
